// File: rtl/vga_pkg.sv
// Shared VGA timing constants, frame-buffer sizing and types for the
// VRAM arbiter slice.
package vga_pkg;
  localparam int H_START = 144;
  localparam int V_START = 31;
  localparam int H_CELLS = 160;
  localparam int V_CELLS = 120;
  localparam int DEPTH   = 19200;

  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 521;

  localparam int XW = 10;
  localparam int AW = 15;
  localparam int DW = 8;

  typedef logic [DW-1:0] rgb332_t;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_HIDLE = 2'd1,
    ST_FETCH = 2'd2
  } arb_state_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// Writer request channel and single-port RAM bus shared by the arbiter
// (slave) and the writer/RAM side (master).
interface vram_arbiter_if;
  import vga_pkg::*;

  // Writer handshake: wr_req is valid and wr_addr/wr_data stay stable until
  // a cycle with wr_ack=1; that cycle completes the transfer (or drops it if
  // the address is out of range). wr_ack is combinational from wr_req.
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  rgb332_t       wr_data;
  logic          wr_ack;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  rgb332_t       mem_wdata;
  rgb332_t       mem_rdata;

  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_fetch_addr.sv
// Display-fetch address generation: 4-cycle slot phase, column counter and
// an incrementally stepped row base (one cell row per 4 visible lines).
module vram_fetch_addr import vga_pkg::*; #(
  parameter int H_CELLS = vga_pkg::H_CELLS
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_fetch_i,
  input  logic          fetch_next_i,
  input  logic          row_done_i,
  input  logic          row_clear_i,
  output logic [1:0]    phase_o,
  output logic [AW-1:0] disp_addr_o
);
  logic [1:0]    phase_q, phase_d;
  logic [1:0]    line_q, line_d;
  logic [7:0]    col_q, col_d;
  logic [AW-1:0] row_base_q, row_base_d;

  always_comb begin
    phase_d    = '0;
    col_d      = '0;
    row_base_d = row_base_q;
    line_d     = line_q;
    // Entering the fetch window restarts at phase 0 / column 0.
    if (fetch_next_i && in_fetch_i) begin
      phase_d = phase_q + 2'd1;
      col_d   = (phase_q == 2'd3) ? col_q + 8'd1 : col_q;
    end
    if (row_clear_i) begin
      row_base_d = '0;
      line_d     = '0;
    end else if (row_done_i) begin
      line_d = line_q + 2'd1;
      if (line_q == 2'd3) row_base_d = row_base_q + AW'(H_CELLS);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q    <= '0;
      col_q      <= '0;
      line_q     <= '0;
      row_base_q <= '0;
    end else begin
      phase_q    <= phase_d;
      col_q      <= col_d;
      line_q     <= line_d;
      row_base_q <= row_base_d;
    end
  end

  assign phase_o     = phase_q;
  assign disp_addr_o = row_base_q + {{(AW-8){1'b0}}, col_q};
endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port frame-buffer RAM between the VGA display fetch
// (phase 0 of each 4-pixel cell) and an external writer (all other cycles).
module vram_arbiter import vga_pkg::*; #(
  parameter int H_START = vga_pkg::H_START,
  parameter int V_START = vga_pkg::V_START,
  parameter int H_CELLS = vga_pkg::H_CELLS,
  parameter int V_CELLS = vga_pkg::V_CELLS,
  parameter int DEPTH   = vga_pkg::DEPTH
) (
  input  logic          new_clk_25,
  input  logic          reset,
  input  logic [XW-1:0] xpos,
  input  logic [XW-1:0] ypos,
  vram_arbiter_if.slave bus,
  input  logic          err_clr,
  output rgb332_t       rgb,
  output logic          vblank,
  output logic          frame_start,
  output logic          addr_err,
  output arb_state_t    dbg_state_o
);
  localparam int H_VIS = 4 * H_CELLS;
  localparam int V_VIS = 4 * V_CELLS;
  localparam logic [XW-1:0] X_VIS_LO   = XW'(H_START);
  localparam logic [XW-1:0] X_VIS_HI   = XW'(H_START + H_VIS - 1);
  localparam logic [XW-1:0] X_FETCH_LO = XW'(H_START - 2);
  localparam logic [XW-1:0] X_FETCH_HI = XW'(H_START + H_VIS - 4);
  localparam logic [XW-1:0] Y_VIS_LO   = XW'(V_START);
  localparam logic [XW-1:0] Y_VIS_HI   = XW'(V_START + V_VIS - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] Y_LAST     = XW'(V_TOTAL - 1);
  localparam logic [AW-1:0] DEPTH_A    = AW'(DEPTH);

  arb_state_t    state_q, state_d;
  rgb332_t       pixel_q, pixel_d;
  logic          addr_err_q, addr_err_d;
  logic          frame_start_q, frame_start_d;
  logic          line_end, row_vis_n, row_vis, col_vis;
  logic [XW-1:0] nx, ny;
  logic [1:0]    phase;
  logic [AW-1:0] disp_addr;
  logic          disp_slot, wr_ok;

  // The state register holds the class of the current pixel, so next state
  // is derived from the following raster position.
  assign line_end  = (xpos == X_LAST);
  assign nx        = line_end ? '0 : xpos + 10'd1;
  assign ny        = line_end ? ((ypos == Y_LAST) ? '0 : ypos + 10'd1) : ypos;
  assign row_vis_n = (ny >= Y_VIS_LO) && (ny <= Y_VIS_HI);
  assign row_vis   = (ypos >= Y_VIS_LO) && (ypos <= Y_VIS_HI);
  assign col_vis   = (xpos >= X_VIS_LO) && (xpos <= X_VIS_HI);

  // BLANK is only left at the first visible line, which keeps row_base in
  // step with the frame after a reset released mid-frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (nx == '0 && ny == Y_VIS_LO) state_d = ST_HIDLE;
      ST_HIDLE, ST_FETCH: begin
        if (!row_vis_n)                                 state_d = ST_BLANK;
        else if (nx >= X_FETCH_LO && nx <= X_FETCH_HI)  state_d = ST_FETCH;
        else                                            state_d = ST_HIDLE;
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    disp_slot     = (state_q == ST_FETCH) && (phase == 2'd0);
    wr_ok         = (bus.wr_addr < DEPTH_A);
    bus.wr_ack    = !reset && bus.wr_req && !disp_slot;
    bus.mem_we    = bus.wr_ack && wr_ok;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (disp_slot) begin
      bus.mem_addr = disp_addr;
    end else if (bus.mem_we) begin
      bus.mem_addr  = bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
    end
    pixel_d       = (state_q == ST_FETCH && phase == 2'd1) ? bus.mem_rdata : pixel_q;
    addr_err_d    = (bus.wr_ack && !wr_ok) || (addr_err_q && !err_clr);
    frame_start_d = (xpos == '0) && (ypos == '0);
    rgb           = (!reset && row_vis && col_vis && state_q != ST_BLANK) ? pixel_q : '0;
    vblank        = !row_vis;
  end

  always_ff @(posedge new_clk_25 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      pixel_q       <= '0;
      addr_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pixel_q       <= pixel_d;
      addr_err_q    <= addr_err_d;
      frame_start_q <= frame_start_d;
    end
  end

  vram_fetch_addr #(.H_CELLS(H_CELLS)) u_fetch_addr (
    .clk_i        (new_clk_25),
    .rst_i        (reset),
    .in_fetch_i   (state_q == ST_FETCH),
    .fetch_next_i (state_d == ST_FETCH),
    .row_done_i   (state_q != ST_BLANK && line_end && row_vis_n),
    .row_clear_i  (state_d == ST_BLANK),
    .phase_o      (phase),
    .disp_addr_o  (disp_addr)
  );

  assign addr_err    = addr_err_q;
  assign frame_start = frame_start_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: raster positions are driven directly,
// RAM is a behavioural 1-cycle-latency model preloaded with addr&0xFF.
module tb_vram_arbiter;
  import vga_pkg::*;

  logic          new_clk_25;
  logic          reset;
  logic [XW-1:0] xpos, ypos;
  logic          err_clr;
  rgb332_t       rgb;
  logic          vblank, frame_start, addr_err;
  arb_state_t    dbg_state;
  rgb332_t       ram [0:32767];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  vram_arbiter_if bus();

  vram_arbiter dut (
    .new_clk_25  (new_clk_25),
    .reset       (reset),
    .xpos        (xpos),
    .ypos        (ypos),
    .bus         (bus),
    .err_clr     (err_clr),
    .rgb         (rgb),
    .vblank      (vblank),
    .frame_start (frame_start),
    .addr_err    (addr_err),
    .dbg_state_o (dbg_state)
  );

  initial new_clk_25 = 1'b0;
  always #5 new_clk_25 = ~new_clk_25;

  always @(posedge new_clk_25) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int x, input int y);
    @(posedge new_clk_25);
    #1;
    xpos = XW'(x);
    ypos = XW'(y);
    #1;
  endtask

  task automatic wr(input logic req, input int a, input int d);
    bus.wr_req  = req;
    bus.wr_addr = AW'(a);
    bus.wr_data = 8'(d);
    #1;
  endtask

  // Walks one line from x=0; pixel k of the line must be (base+k)&0xFF.
  task automatic run_line(input int y, input int base, input bit with_wr, input int x_end);
    int acks = 0;
    for (int x = 0; x <= x_end; x++) begin
      cyc(x, y);
      if (with_wr) begin
        if (x == 142 || x == 143)     wr(1'b1, 100, 100);
        else if (x >= 200 && x < 300) wr(1'b1, 1000 + x, 1000 + x);
        else if (x == 144 || x == 300) wr(1'b0, 0, 0);
        if (x == 142) check("holdoff_ack", 32'(bus.wr_ack), 32'd0);
        if (x == 143) begin
          check("late_ack", 32'(bus.wr_ack), 32'd1);
          check("late_addr", 32'(bus.mem_addr), 32'd100);
          check("late_we", 32'(bus.mem_we), 32'd1);
        end
        if (x >= 200 && x < 300) begin
          if (bus.wr_ack) acks++;
          if (((x - 142) % 4) == 0) begin
            check($sformatf("disp_addr_x%0d", x), 32'(bus.mem_addr), 32'(base + (x - 142) / 4));
            check($sformatf("disp_we_x%0d", x), 32'(bus.mem_we), 32'd0);
          end
        end
      end
      if (x == 141) check("state_hidle", 32'(dbg_state), 32'(ST_HIDLE));
      if (x == 142) begin
        check($sformatf("first_fetch_y%0d", y), 32'(bus.mem_addr), 32'(base));
        check("first_fetch_we", 32'(bus.mem_we), 32'd0);
        check("state_fetch", 32'(dbg_state), 32'(ST_FETCH));
      end
      if (x == 778) check($sformatf("last_fetch_y%0d", y), 32'(bus.mem_addr), 32'(base + 159));
      if (x >= 144 && x < 784)
        check($sformatf("rgb_x%0d_y%0d", x, y), 32'(rgb), 32'((base + (x - 144) / 4) & 255));
      else
        check($sformatf("rgb_x%0d_y%0d", x, y), 32'(rgb), 32'd0);
    end
    if (with_wr) check("ack_count", 32'(acks), 32'd75);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] <= 8'(i);
    reset   = 1'b1;
    err_clr = 1'b0;
    xpos    = '0;
    ypos    = '0;
    wr(1'b0, 0, 0);

    // Reset state
    repeat (3) @(posedge new_clk_25);
    #1;
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_ack", 32'(bus.wr_ack), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_BLANK));
    reset = 1'b0;

    // frame_start pulse after (0,0); writes in blanking
    cyc(1, 0);
    check("frame_start_hi", 32'(frame_start), 32'd1);
    check("vblank_y0", 32'(vblank), 32'd1);
    cyc(2, 0);
    check("frame_start_lo", 32'(frame_start), 32'd0);
    wr(1'b1, 5, 5);
    check("blank_ack", 32'(bus.wr_ack), 32'd1);
    check("blank_we", 32'(bus.mem_we), 32'd1);
    check("blank_addr", 32'(bus.mem_addr), 32'd5);
    check("blank_wdata", 32'(bus.mem_wdata), 32'd5);

    // Out-of-range writes and addr_err stickiness
    cyc(3, 0);
    wr(1'b1, 19200, 8'hAA);
    check("bad_ack", 32'(bus.wr_ack), 32'd1);
    check("bad_we", 32'(bus.mem_we), 32'd0);
    check("bad_err_not_yet", 32'(addr_err), 32'd0);
    cyc(4, 0);
    wr(1'b0, 0, 0);
    check("bad_err_set", 32'(addr_err), 32'd1);
    cyc(5, 0);
    check("bad_err_sticky", 32'(addr_err), 32'd1);
    cyc(6, 0);
    err_clr = 1'b1;
    wr(1'b1, 19201, 8'hBB);
    check("bad2_ack", 32'(bus.wr_ack), 32'd1);
    check("bad2_we", 32'(bus.mem_we), 32'd0);
    cyc(7, 0);
    err_clr = 1'b0;
    wr(1'b0, 0, 0);
    check("set_beats_clr", 32'(addr_err), 32'd1);
    cyc(8, 0);
    err_clr = 1'b1;
    cyc(9, 0);
    err_clr = 1'b0;
    check("err_cleared", 32'(addr_err), 32'd0);

    // First visible line with writer hold-off and continuous writes
    cyc(798, 30);
    cyc(799, 30);
    check("vblank_y30", 32'(vblank), 32'd1);
    check("state_blank_y30", 32'(dbg_state), 32'(ST_BLANK));
    run_line(31, 0, 1'b1, 799);

    // Row base on visible line 4, then skip to line 479
    for (int y = 32; y <= 34; y++) cyc(799, y);
    run_line(35, 160, 1'b0, 799);
    for (int y = 36; y <= 509; y++) cyc(799, y);
    run_line(510, 19040, 1'b0, 799);
    cyc(0, 511);
    check("vblank_y511", 32'(vblank), 32'd1);
    check("state_blank_y511", 32'(dbg_state), 32'(ST_BLANK));

    // Reset mid-FETCH with a write in flight
    cyc(798, 30);
    cyc(799, 30);
    run_line(31, 0, 1'b0, 200);
    cyc(201, 31);
    wr(1'b1, 300, 8'h5A);
    check("pre_rst_ack", 32'(bus.wr_ack), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_ack", 32'(bus.wr_ack), 32'd0);
    check("midrst_we", 32'(bus.mem_we), 32'd0);
    check("midrst_rgb", 32'(rgb), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_BLANK));
    cyc(202, 31);
    check("rst_hold_ack", 32'(bus.wr_ack), 32'd0);
    cyc(203, 31);
    wr(1'b0, 0, 0);
    reset = 1'b0;
    for (int x = 204; x < 800; x++) begin
      cyc(x, 31);
      check($sformatf("post_rst_rgb_x%0d", x), 32'(rgb), 32'd0);
    end
    check("aborted_write", 32'(ram[300]), 32'h2C);
    cyc(798, 30);
    cyc(799, 30);
    run_line(31, 0, 1'b0, 799);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameters: H_START 144, first visible xpos; V_START 31, first visible ypos; H_CELLS 160, cells per row; V_CELLS 120, cell rows; DEPTH 19200, frame-buffer words.
REQ-002 SHALL have ports (name, direction, width, meaning):
- new_clk_25  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- xpos  in  10  horizontal pixel counter, 0..799.
- ypos  in  10  vertical line counter, 0..520.
- wr_req  in  1  writer request; wr_addr/wr_data held stable until acked.
- wr_addr  in  15  writer cell address.
- wr_data  in  8  writer RGB332 data.
- wr_ack  out  1  write performed this cycle.
- mem_addr  out  15  single-port RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, 1-cycle synchronous latency.
- err_clr  in  1  clears addr_err.
- rgb  out  8  pixel colour.
- vblank  out  1  ypos outside visible rows.
- frame_start  out  1  one-cycle pulse when xpos=0 and ypos=0.
- addr_err  out  1  sticky out-of-range write flag.

Function
REQ-003 SHALL treat a cycle as visible iff H_START<=xpos<H_START+640 and V_START<=ypos<V_START+480; each cell is 4x4 pixels.
REQ-004 SHALL run FSM states BLANK (ypos not visible), HIDLE (visible row, outside fetch window) and FETCH (H_START-2<=xpos<=H_START+636 on a visible row).
REQ-005 SHALL advance state on xpos/ypos each cycle, with no other transition conditions.
REQ-006 SHALL, in FETCH, issue a display read (mem_we=0, mem_addr=row_base+k) when xpos=H_START-2+4k, k=0..159 (phase 0), and SHALL give phases 1-3 to the writer.
REQ-007 SHALL latch mem_rdata into pixel_reg at the edge ending the cycle with xpos=H_START-1+4k, so cell k is held for xpos H_START+4k..H_START+4k+3.
REQ-008 SHALL drive rgb=pixel_reg in visible cycles and 0 otherwise.
REQ-009 SHALL compute row_base incrementally, with no multiplier: it is 0 on the first visible line and adds 160 after every 4th visible line (0,160,...,19040).
REQ-010 SHALL grant the writer in every BLANK and HIDLE cycle and on FETCH phases 1-3; on a grant with wr_req=1, mem_addr=wr_addr, mem_wdata=wr_data, and wr_ack=1 combinationally.
REQ-011 SHALL hold off a wr_req that coincides with a display slot (wr_ack=0) and SHALL ack it on the next cycle.
REQ-012 SHALL, for wr_addr>=DEPTH, pulse wr_ack with mem_we=0 (write dropped) and set addr_err.
REQ-013 SHALL let a set of addr_err win over err_clr in the same cycle.
REQ-014 SHALL drive mem_we=0 and mem_addr=0 when neither display nor writer uses the port.
REQ-015 SHALL assert vblank combinationally from ypos; frame_start is registered, asserted in the cycle after xpos=0,ypos=0.

Reset
REQ-016 SHALL on reset: FSM=BLANK, pixel_reg=0, row_base=0, addr_err=0, frame_start=0, and rgb/wr_ack/mem_we=0 immediately.
REQ-017 SHALL abort a write in progress at reset with no ack.
REQ-018 SHALL resume after reset release at the next visible line start, with no stale pixel_reg shown.

Structure
REQ-019 SHALL place H_START, V_START, H_CELLS, V_CELLS, DEPTH, the FSM state encoding and the RGB332 type in shared package vga_pkg.
REQ-020 SHALL use one sub-module, vram_fetch_addr, for the row_base/column address counters and phase counter; the arbiter FSM and grant logic stay in the top module.

Verification
REQ-021 SHALL cover: RAM preloaded addr=data&0xFF, run one frame -> rgb at xpos=144+4k on the first visible line equals k for k=0..159, and rgb=0 at xpos 143 and 784.
REQ-022 SHALL cover: wr_req held at xpos=142 on a visible line (phase 0) -> wr_ack=0 at 142, wr_ack=1 at 143 with mem_addr=wr_addr.
REQ-023 SHALL cover: continuous wr_req during FETCH -> exactly 3 acks per 4 cycles and display reads undisturbed.
REQ-024 SHALL cover: wr_addr=19200 -> wr_ack=1, mem_we=0, addr_err=1 until err_clr; err_clr coincident with a new bad write -> addr_err stays 1.
REQ-025 SHALL cover: visible line 4 (ypos=35) -> first fetch mem_addr=160; line 479 (ypos=510) -> last fetch mem_addr=19199.
REQ-026 SHALL cover: reset asserted mid-FETCH with wr_req=1 -> wr_ack, mem_we, rgb=0 same cycle, and correct pixels on the first visible line after release.
